// File: rtl/fifo_wr_arbiter_if.sv
// Requester-to-FIFO write bus between N_REQ requesters and a single FIFO write port.
// master: the arbiter side; slave: the requester/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned Width = 8,
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned GW = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*Width-1:0] req_data;
  logic [N_REQ-1:0]       req_ready;
  logic                   full;
  logic                   w_en;
  logic [Width-1:0]       data_in;
  logic [GW-1:0]          grant_id;
  logic                   busy;
  logic [15:0]            wr_count;

  modport master (
    input  req_valid, req_data, full,
    output req_ready, w_en, data_in, grant_id, busy, wr_count
  );

  modport slave (
    output req_valid, req_data, full,
    input  req_ready, w_en, data_in, grant_id, busy, wr_count
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that grants one requester at a time a burst of up to MAX_BURST
// beats into a shared FIFO write port, with a one-cycle arbitration bubble between grants.
module fifo_wr_arbiter #(
  parameter int unsigned Width     = 8,
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                wclk,
  input  logic                wrst_n,
  fifo_wr_arbiter_if.master   bus
);
  localparam int unsigned GW  = $clog2(N_REQ);
  localparam int unsigned GW1 = GW + 1;
  localparam int unsigned BW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grant_id;
  logic [GW-1:0]   r_last_gnt;
  logic [BW-1:0]   r_burst;
  logic [15:0]     r_wr_count;

  logic [N_REQ-1:0][Width-1:0] w_data_2d;
  logic [Width-1:0]            w_sel_data;
  logic                        w_sel_valid;
  logic                        w_beat;
  logic                        w_found;
  logic [GW-1:0]               w_pick;
  logic [GW1-1:0]              w_idx;
  logic [N_REQ-1:0]            w_ready;

  assign w_data_2d   = bus.req_data;
  assign w_sel_data  = w_data_2d[r_grant_id];
  assign w_sel_valid = bus.req_valid[r_grant_id];

  // Reset gates the write strobe combinationally so a mid-burst reset writes nothing.
  assign w_beat = wrst_n && (r_state == GRANT) && w_sel_valid && !bus.full;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = GW1'(r_last_gnt) + GW1'(k) + GW1'(1);
      if (w_idx >= GW1'(N_REQ)) w_idx = w_idx - GW1'(N_REQ);
      if (!w_found && bus.req_valid[w_idx[GW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[GW-1:0];
      end
    end
  end

  always_comb begin
    w_ready             = '0;
    w_ready[r_grant_id] = w_beat;
  end

  assign bus.w_en      = w_beat;
  assign bus.req_ready = w_ready;
  assign bus.data_in   = (r_state == GRANT) ? w_sel_data : '0;
  assign bus.busy      = (r_state == GRANT);
  assign bus.grant_id  = r_grant_id;
  assign bus.wr_count  = r_wr_count;

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      r_state    <= IDLE;
      r_grant_id <= '0;
      r_last_gnt <= GW'(N_REQ - 1);
      r_burst    <= '0;
      r_wr_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant_id <= w_pick;
            r_burst    <= '0;
            r_state    <= GRANT;
          end
        end
        GRANT: begin
          if (!w_sel_valid) begin
            r_state    <= IDLE;
            r_last_gnt <= r_grant_id;
          end else if (w_beat) begin
            r_burst    <= r_burst + BW'(1);
            r_wr_count <= r_wr_count + 16'd1;
            if (r_burst == BW'(MAX_BURST - 1)) begin
              r_state    <= IDLE;
              r_last_gnt <= r_grant_id;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, each cycle checked
// against a transaction-level model of grants, bursts and the beat counter.
module tb_fifo_wr_arbiter;
  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned MB = 4;
  localparam int unsigned GW = $clog2(N);
  localparam int unsigned VW = 1 + N + W + 1 + GW + 16;

  logic wclk   = 1'b0;
  logic wrst_n = 1'b0;
  always #5 wclk = ~wclk;

  fifo_wr_arbiter_if #(.Width(W), .N_REQ(N)) bus ();

  fifo_wr_arbiter #(.Width(W), .N_REQ(N), .MAX_BURST(MB)) dut (
    .wclk  (wclk),
    .wrst_n(wrst_n),
    .bus   (bus.master)
  );

  int n_err = 0;
  int n_chk = 0;

  // Model: whether a grant is open, who holds it, beats so far, last owner, total beats.
  bit          m_busy  = 1'b0;
  int          m_gid   = 0;
  int          m_beats = 0;
  int          m_last  = N - 1;
  logic [15:0] m_cnt   = '0;

  logic          exp_wen;
  logic [N-1:0]  exp_rdy;
  logic [W-1:0]  exp_data;
  logic [VW-1:0] obs, expv;

  function automatic logic [N*W-1:0] rnd();
    logic [N*W-1:0] x;
    for (int i = 0; i < N; i++) x[i*W +: W] = W'($urandom);
    return x;
  endfunction

  // Apply inputs for this cycle, then capture DUT outputs and model expectations.
  task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic f, input logic r);
    bus.req_valid = v;
    bus.req_data  = d;
    bus.full      = f;
    wrst_n        = r;
    #1;
    exp_wen  = r && m_busy && v[m_gid] && !f;
    exp_rdy  = '0;
    if (exp_wen) exp_rdy[m_gid] = 1'b1;
    exp_data = m_busy ? d[m_gid*W +: W] : '0;
    obs  = {bus.w_en, bus.req_ready, bus.data_in, bus.busy, bus.grant_id, bus.wr_count};
    expv = {exp_wen, exp_rdy, exp_data, m_busy, GW'(m_gid), m_cnt};
  endtask

  // Clock edge: advance the model with the inputs held across the edge.
  task automatic tick();
    @(posedge wclk);
    if (!wrst_n) begin
      m_busy = 1'b0; m_gid = 0; m_last = N - 1; m_beats = 0; m_cnt = '0;
    end else if (!m_busy) begin
      for (int k = 1; k <= N; k++) begin
        int i;
        i = (m_last + k) % N;
        if (bus.req_valid[i]) begin
          m_gid = i; m_beats = 0; m_busy = 1'b1;
          break;
        end
      end
    end else if (!bus.req_valid[m_gid]) begin
      m_busy = 1'b0; m_last = m_gid;
    end else if (!bus.full) begin
      m_cnt   = m_cnt + 16'd1;
      m_beats = m_beats + 1;
      if (m_beats == MB) begin
        m_busy = 1'b0; m_last = m_gid;
      end
    end
    @(negedge wclk);
  endtask

  task automatic do_reset();
    drive('0, '0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    drive('0, '0, 1'b0, 1'b1);
    n_chk++; if (obs !== expv) begin n_err++; $display("FAIL reset_model got=%h exp=%h", obs, expv); end
    n_chk++; if ({bus.busy, bus.grant_id, bus.wr_count} !== 19'd0) begin
      n_err++; $display("FAIL reset_vals got busy=%b gid=%0d cnt=%0d exp 0/0/0", bus.busy, bus.grant_id, bus.wr_count);
    end
    drive(4'hF, rnd(), 1'b0, 1'b0);
    n_chk++; if ({bus.w_en, bus.req_ready} !== 5'd0) begin
      n_err++; $display("FAIL reset_hold got w_en=%b ready=%b exp 0/0000", bus.w_en, bus.req_ready);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [GW-1:0] grants[$];
    int  c_first = -1;
    bit  prev = 1'b0;
    do_reset();
    for (int c = 0; c <= 26; c++) begin
      drive(4'hF, rnd(), 1'b0, 1'b1);
      n_chk++; if (obs !== expv) begin n_err++; $display("FAIL rr_model c=%0d got=%h exp=%h", c, obs, expv); end
      if (bus.busy && !prev) grants.push_back(bus.grant_id);
      if (bus.busy && c_first < 0) c_first = c;
      if (c_first >= 0 && c == c_first + 25) begin
        n_chk++; if (bus.wr_count !== 16'd20) begin
          n_err++; $display("FAIL rr_count got=%0d exp=20", bus.wr_count);
        end
      end
      prev = bus.busy;
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (grants.size() <= i || grants[i] !== GW'(i % N)) begin
        n_err++; $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i,
                          (grants.size() > i) ? int'(grants[i]) : -1, i % N);
      end
    end
  endtask

  task automatic test_single_req();
    logic [N*W-1:0] d;
    logic           en_exp;
    do_reset();
    d = rnd();
    d[2*W +: W] = 8'hA5;
    for (int c = 0; c <= 10; c++) begin
      drive(4'b0100, d, 1'b0, 1'b1);
      n_chk++; if (obs !== expv) begin n_err++; $display("FAIL single_model c=%0d got=%h exp=%h", c, obs, expv); end
      en_exp = ((c % 5) != 0);
      n_chk++; if (bus.w_en !== en_exp) begin n_err++; $display("FAIL single_wen c=%0d got=%b exp=%b", c, bus.w_en, en_exp); end
      if (en_exp) begin
        n_chk++; if (bus.data_in !== 8'hA5 || bus.grant_id !== GW'(2)) begin
          n_err++; $display("FAIL single_data c=%0d got=%h/%0d exp=a5/2", c, bus.data_in, bus.grant_id);
        end
      end
      tick();
    end
  endtask

  task automatic test_full_stall();
    int   beats = 0;
    logic f;
    do_reset();
    for (int c = 0; c <= 8; c++) begin
      f = (c >= 3 && c <= 5);
      drive(4'b0010, rnd(), f, 1'b1);
      n_chk++; if (obs !== expv) begin n_err++; $display("FAIL stall_model c=%0d got=%h exp=%h", c, obs, expv); end
      if (f) begin
        n_chk++; if ({bus.w_en, bus.req_ready} !== 5'd0 || bus.busy !== 1'b1) begin
          n_err++; $display("FAIL stall_hold c=%0d got w_en=%b ready=%b busy=%b exp 0/0000/1", c, bus.w_en, bus.req_ready, bus.busy);
        end
      end
      if (bus.w_en === 1'b1) beats++;
      if (c == 8) begin
        n_chk++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL stall_release got busy=%b exp 0", bus.busy); end
      end
      tick();
    end
    n_chk++; if (beats != 4) begin n_err++; $display("FAIL stall_beats got=%0d exp=4", beats); end
  endtask

  task automatic test_drop_valid();
    do_reset();
    drive(4'b1001, rnd(), 1'b0, 1'b1);
    n_chk++; if (obs !== expv) begin n_err++; $display("FAIL drop_model0 got=%h exp=%h", obs, expv); end
    tick();
    drive(4'b1001, rnd(), 1'b0, 1'b1);
    n_chk++; if (bus.w_en !== 1'b1 || bus.grant_id !== GW'(0)) begin
      n_err++; $display("FAIL drop_beat got w_en=%b gid=%0d exp 1/0", bus.w_en, bus.grant_id);
    end
    tick();
    drive(4'b1000, rnd(), 1'b0, 1'b1);
    n_chk++; if (obs !== expv || bus.w_en !== 1'b0) begin n_err++; $display("FAIL drop_nobeat got=%h exp=%h", obs, expv); end
    tick();
    drive(4'b1000, rnd(), 1'b0, 1'b1);
    n_chk++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL drop_idle got busy=%b exp 0", bus.busy); end
    tick();
    drive(4'b1000, rnd(), 1'b0, 1'b1);
    n_chk++; if (bus.busy !== 1'b1 || bus.grant_id !== GW'(3)) begin
      n_err++; $display("FAIL drop_regrant got busy=%b gid=%0d exp 1/3", bus.busy, bus.grant_id);
    end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    drive('0, '0, 1'b0, 1'b1);
    force dut.r_wr_count = 16'hFFFE;
    m_cnt = 16'hFFFE;
    tick();
    release dut.r_wr_count;
    for (int c = 0; c <= 4; c++) begin
      drive(4'b0001, rnd(), 1'b0, 1'b1);
      n_chk++; if (obs !== expv) begin n_err++; $display("FAIL wrap_model c=%0d got=%h exp=%h", c, obs, expv); end
      if (c == 4) begin
        n_chk++; if (bus.wr_count !== 16'h0001) begin n_err++; $display("FAIL wrap_count got=%h exp=0001", bus.wr_count); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    drive(4'b1100, rnd(), 1'b0, 1'b1);
    tick();
    drive(4'b1100, rnd(), 1'b0, 1'b1);
    n_chk++; if (bus.w_en !== 1'b1 || bus.grant_id !== GW'(2)) begin
      n_err++; $display("FAIL rstmid_first got w_en=%b gid=%0d exp 1/2", bus.w_en, bus.grant_id);
    end
    tick();
    drive(4'b1100, rnd(), 1'b0, 1'b0);
    n_chk++; if ({bus.w_en, bus.req_ready} !== 5'd0 || obs !== expv) begin
      n_err++; $display("FAIL rstmid_gate got w_en=%b ready=%b exp 0/0000", bus.w_en, bus.req_ready);
    end
    tick();
    drive(4'b1100, rnd(), 1'b0, 1'b1);
    n_chk++; if (bus.busy !== 1'b0 || bus.wr_count !== 16'd0) begin
      n_err++; $display("FAIL rstmid_after got busy=%b cnt=%0d exp 0/0", bus.busy, bus.wr_count);
    end
    tick();
    drive(4'b1100, rnd(), 1'b0, 1'b1);
    n_chk++; if (bus.busy !== 1'b1 || bus.grant_id !== GW'(2)) begin
      n_err++; $display("FAIL rstmid_regrant got busy=%b gid=%0d exp 1/2", bus.busy, bus.grant_id);
    end
    tick();
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    logic         f, r;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      v = N'($urandom);
      f = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 63) != 0);
      drive(v, rnd(), f, r);
      n_chk++; if (obs !== expv) begin n_err++; $display("FAIL random_model c=%0d got=%h exp=%h", c, obs, expv); end
      tick();
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.full      = 1'b0;
    @(negedge wclk);
    test_reset();
    test_round_robin();
    test_single_req();
    test_full_stall();
    test_drop_valid();
    test_wrap();
    test_reset_mid_burst();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter Width, default 8: FIFO data width in bits.
REQ-002 SHALL have parameter N_REQ, default 4: number of write requesters (2..8).
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum beats per grant (1..16).
REQ-004 SHALL have port wclk  input  1  write-domain clock; all state updates on posedge wclk.
REQ-005 SHALL have port wrst_n  input  1  reset. One clock; reset is synchronous and active-low.
REQ-006 SHALL have port req_valid  input  N_REQ  per-requester data-valid.
REQ-007 SHALL have port req_data  input  N_REQ*Width  requester i data in bits [i*Width +: Width].
REQ-008 SHALL have port req_ready  output  N_REQ  per-requester beat-accepted.
REQ-009 SHALL have port full  input  1  FIFO full flag.
REQ-010 SHALL have port w_en  output  1  FIFO write enable.
REQ-011 SHALL have port data_in  output  Width  FIFO write data.
REQ-012 SHALL have port grant_id  output  $clog2(N_REQ)  currently or last granted requester index.
REQ-013 SHALL have port busy  output  1  high while in GRANT state.
REQ-014 SHALL have port wr_count  output  16  total beats written since reset.

Function
REQ-015 SHALL implement two states, IDLE and GRANT; busy = (state == GRANT).
REQ-016 In IDLE, if any req_valid is high, the block SHALL select the first valid requester searching round-robin from last_gnt+1 (mod N_REQ), register it into grant_id, clear burst counter, and enter GRANT next cycle.
REQ-017 In IDLE, the block SHALL assert no w_en and no req_ready (one-cycle arbitration bubble).
REQ-018 In GRANT, w_en SHALL be combinational: req_valid[grant_id] && !full.
REQ-019 req_ready[grant_id] SHALL equal w_en; all other req_ready bits SHALL be 0.
REQ-020 data_in SHALL be combinationally muxed from req_data slice grant_id in GRANT, and 0 in IDLE.
REQ-021 Each cycle with w_en high is one beat; the burst counter and wr_count SHALL each increment by 1 on a beat.
REQ-022 wr_count SHALL wrap from 0xFFFF to 0x0000.
REQ-023 When a beat brings the burst count to MAX_BURST, the block SHALL return to IDLE next cycle and set last_gnt = grant_id.
REQ-024 If req_valid[grant_id] is low in GRANT, the block SHALL return to IDLE next cycle with no beat and set last_gnt = grant_id.
REQ-025 While full is high in GRANT with req_valid[grant_id] high, the block SHALL hold state, grant_id and burst count; no beat and no timeout.
REQ-026 Valid changes on non-granted requesters during GRANT SHALL have no effect until the next IDLE.
REQ-027 A requester holding valid high SHALL be granted within N_REQ arbitration rounds (no starvation).

Reset
REQ-028 With wrst_n low at posedge wclk, the block SHALL set state = IDLE, grant_id = 0, last_gnt = N_REQ-1, burst count = 0, and wr_count = 0.
REQ-029 While wrst_n is low, w_en and req_ready SHALL be forced to 0 combinationally, including reset asserted mid-burst in GRANT.
REQ-030 After release, the first arbitration SHALL search from requester 0.

Verification
REQ-031 Reset, then req_valid = 4'b1111 held and full = 0 -> grants 0,1,2,3,0... with 4 beats each, one bubble cycle between grants, and wr_count = 20 after 25 cycles from first grant.
REQ-032 Only req 2 valid, data 8'hA5 held -> grant_id = 2, w_en high for 4 cycles with data_in = 8'hA5, IDLE for 1 cycle, then re-grant to 2.
REQ-033 Grant to req 1, full high for 3 cycles after the 2nd beat -> w_en = 0 and req_ready = 0 for those 3 cycles, then 2 more beats and release; total of exactly 4 beats.
REQ-034 Grant to req 0, req_valid[0] drops after 1 beat while req 3 is valid -> IDLE next cycle, then grant_id = 3.
REQ-035 Preload wr_count to 16'hFFFE via 65534 beats (or force), then 3 beats -> wr_count reads 16'h0001.
REQ-036 wrst_n low during the 2nd beat of a burst -> w_en = 0 in the same cycle, state IDLE and wr_count = 0 after the edge, first grant after release goes to the lowest valid index.
